mc_control_fsm: RTL and testbench

Multicycle main controller for the MIPS core. It sequences the shared datapath (PC, unified instruction/data memory, IR, register file, ALU with its opcode/funct ALU decoder) through fetch, decode, execute, memory and writeback. It spends a variable number of cycles per instruction and stalls on a memory ready handshake. It produces every datapath enable and mux select, plus the ALU operation source select that decides between a forced ADD/SUB and the ALU decoder's output.

---
 rtl/mc_control_fsm.sv | 128 ++++++++++++
 tb/tb_mc_control_fsm.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS controller sequencing fetch/decode/execute/memory/writeback; emits all datapath enables, mux selects and debug state
module mc_control_fsm (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_opcode,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic       o_pc_write_cond_ne,
  output logic       o_iord,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_reg_write,
  output logic       o_reg_dst,
  output logic       o_mem_to_reg,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic       o_imm_zext,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_pc_src,
  output logic       o_illegal,
  output logic [3:0] o_state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, IMMEX = 4'd9, IMMWB = 4'd10, JUMP = 4'd11
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
    OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_ANDI = 6'b001100, OP_ORI = 6'b001101,
    OP_XORI = 6'b001110, OP_LW = 6'b100011, OP_SW = 6'b101011;
  state_t state, next;
  logic is_zext, is_imm;
  assign is_zext = i_opcode == OP_ANDI || i_opcode == OP_ORI || i_opcode == OP_XORI;
  assign is_imm = is_zext || i_opcode == OP_ADDI || i_opcode == OP_SLTI;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= FETCH;
    else state <= next;
  always_comb begin
    next = FETCH;
    o_pc_write = 1'b0;
    o_pc_write_cond = 1'b0;
    o_pc_write_cond_ne = 1'b0;
    o_iord = 1'b0;
    o_mem_read = 1'b0;
    o_mem_write = 1'b0;
    o_ir_write = 1'b0;
    o_reg_write = 1'b0;
    o_reg_dst = 1'b0;
    o_mem_to_reg = 1'b0;
    o_alu_src_a = 1'b0;
    o_alu_src_b = 2'b00;
    o_imm_zext = 1'b0;
    o_alu_op = 2'b00;
    o_pc_src = 2'b00;
    o_illegal = 1'b0;
    o_state = state;
    // outputs are gated by reset so they drop with no clock edge
    if (i_rst_n)
      case (state)
        FETCH: begin
          o_mem_read = 1'b1;
          o_alu_src_b = 2'b01;
          o_ir_write = i_mem_ready;
          o_pc_write = i_mem_ready;
          next = i_mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          o_alu_src_b = 2'b11;
          next = (i_opcode == OP_LW || i_opcode == OP_SW) ? MEMADR :
                 i_opcode == OP_R ? EXEC :
                 (i_opcode == OP_BEQ || i_opcode == OP_BNE) ? BRANCH :
                 is_imm ? IMMEX :
                 i_opcode == OP_J ? JUMP : FETCH;
          o_illegal = next == FETCH;
        end
        MEMADR: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = 2'b10;
          next = i_opcode == OP_LW ? MEMRD : MEMWR;
        end
        MEMRD: begin
          o_mem_read = 1'b1;
          o_iord = 1'b1;
          next = i_mem_ready ? MEMWB : MEMRD;
        end
        MEMWB: begin
          o_reg_write = 1'b1;
          o_mem_to_reg = 1'b1;
        end
        MEMWR: begin
          o_mem_write = 1'b1;
          o_iord = 1'b1;
          next = i_mem_ready ? FETCH : MEMWR;
        end
        EXEC: begin
          o_alu_src_a = 1'b1;
          o_alu_op = 2'b10;
          next = ALUWB;
        end
        ALUWB: begin
          o_reg_write = 1'b1;
          o_reg_dst = 1'b1;
        end
        BRANCH: begin
          o_alu_src_a = 1'b1;
          o_alu_op = 2'b01;
          o_pc_src = 2'b01;
          o_pc_write_cond = i_opcode == OP_BEQ;
          o_pc_write_cond_ne = i_opcode == OP_BNE;
        end
        IMMEX: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = 2'b10;
          o_alu_op = 2'b10;
          o_imm_zext = is_zext;
          next = IMMWB;
        end
        IMMWB: o_reg_write = 1'b1;
        JUMP: begin
          o_pc_write = 1'b1;
          o_pc_src = 2'b10;
        end
        default: next = FETCH;
      endcase
  end
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: randomized scoreboard bench for mc_control_fsm against an instruction-level model
module tb_mc_control_fsm;
  typedef struct packed {
    logic pcw, pcc, pcn, iord, mr, mw, irw, rw, rd, m2r, sa;
    logic [1:0] sb;
    logic zx;
    logic [1:0] aop, psrc;
    logic ill;
    logic [3:0] st;
  } vec_t;
  typedef struct packed {
    logic [5:0] op;
    logic zero, rdy;
  } stim_t;
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_zero = 1'b0, i_mem_ready = 1'b0;
  logic [5:0] i_opcode = 6'd0;
  logic o_pc_write, o_pc_write_cond, o_pc_write_cond_ne, o_iord, o_mem_read, o_mem_write;
  logic o_ir_write, o_reg_write, o_reg_dst, o_mem_to_reg, o_alu_src_a, o_imm_zext, o_illegal;
  logic [1:0] o_alu_src_b, o_alu_op, o_pc_src;
  logic [3:0] o_state;
  vec_t act;
  stim_t stim_q[$];
  vec_t exp_q[$];
  int tests = 0, fails = 0;
  logic mon_on = 1'b0;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
    BNE = 6'b000101, ADDI = 6'b001000, SLTI = 6'b001010, ANDI = 6'b001100, ORI = 6'b001101,
    XORI = 6'b001110, JMP = 6'b000010, BAD = 6'b111111;
  logic [5:0] op_tab [12] = '{LW, SW, RT, BEQ, BNE, ADDI, SLTI, ANDI, ORI, XORI, JMP, BAD};

  mc_control_fsm dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .i_zero(i_zero),
    .i_mem_ready(i_mem_ready), .o_pc_write(o_pc_write), .o_pc_write_cond(o_pc_write_cond),
    .o_pc_write_cond_ne(o_pc_write_cond_ne), .o_iord(o_iord), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_ir_write(o_ir_write), .o_reg_write(o_reg_write),
    .o_reg_dst(o_reg_dst), .o_mem_to_reg(o_mem_to_reg), .o_alu_src_a(o_alu_src_a),
    .o_alu_src_b(o_alu_src_b), .o_imm_zext(o_imm_zext), .o_alu_op(o_alu_op),
    .o_pc_src(o_pc_src), .o_illegal(o_illegal), .o_state(o_state)
  );
  assign act = {o_pc_write, o_pc_write_cond, o_pc_write_cond_ne, o_iord, o_mem_read, o_mem_write,
                o_ir_write, o_reg_write, o_reg_dst, o_mem_to_reg, o_alu_src_a, o_alu_src_b,
                o_imm_zext, o_alu_op, o_pc_src, o_illegal, o_state};
  always #5 i_clk = ~i_clk;

  task automatic chk(string name, vec_t got, vec_t want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h (state got %0d want %0d)", name, got, want, got.st, want.st);
    end
  endtask

  function automatic vec_t v(int st);
    vec_t r = '0;
    r.st = st[3:0];
    return r;
  endfunction

  task automatic push(logic [5:0] op, logic rdy, vec_t e);
    stim_q.push_back('{op: op, zero: 1'($urandom_range(0, 1)), rdy: rdy});
    exp_q.push_back(e);
  endtask

  // one instruction: fetch stalls fst cycles, memory access stalls mst cycles
  task automatic gen(logic [5:0] op, int fst, int mst);
    vec_t e;
    logic is_zx, is_imm;
    is_zx = op == ANDI || op == ORI || op == XORI;
    is_imm = is_zx || op == ADDI || op == SLTI;
    e = v(0); e.mr = 1; e.sb = 2'b01;
    for (int i = 0; i < fst; i++) push(6'($urandom), 1'b0, e);
    e.irw = 1; e.pcw = 1;
    push(6'($urandom), 1'b1, e);
    e = v(1); e.sb = 2'b11;
    e.ill = !(op == LW || op == SW || op == RT || op == BEQ || op == BNE || is_imm || op == JMP);
    push(op, 1'($urandom_range(0, 1)), e);
    if (op == LW || op == SW) begin
      e = v(2); e.sa = 1; e.sb = 2'b10;
      push(op, 1'($urandom_range(0, 1)), e);
      e = v(op == LW ? 3 : 5); e.iord = 1;
      if (op == LW) e.mr = 1; else e.mw = 1;
      for (int i = 0; i < mst; i++) push(op, 1'b0, e);
      push(op, 1'b1, e);
      if (op == LW) begin
        e = v(4); e.rw = 1; e.m2r = 1;
        push(op, 1'($urandom_range(0, 1)), e);
      end
    end else if (op == RT) begin
      e = v(6); e.sa = 1; e.aop = 2'b10;
      push(op, 1'($urandom_range(0, 1)), e);
      e = v(7); e.rw = 1; e.rd = 1;
      push(op, 1'($urandom_range(0, 1)), e);
    end else if (op == BEQ || op == BNE) begin
      e = v(8); e.sa = 1; e.aop = 2'b01; e.psrc = 2'b01;
      e.pcc = op == BEQ; e.pcn = op == BNE;
      push(op, 1'($urandom_range(0, 1)), e);
    end else if (is_imm) begin
      e = v(9); e.sa = 1; e.sb = 2'b10; e.aop = 2'b10; e.zx = is_zx;
      push(op, 1'($urandom_range(0, 1)), e);
      e = v(10); e.rw = 1;
      push(op, 1'($urandom_range(0, 1)), e);
    end else if (op == JMP) begin
      e = v(11); e.pcw = 1; e.psrc = 2'b10;
      push(op, 1'($urandom_range(0, 1)), e);
    end
  endtask

  always @(negedge i_clk)
    if (mon_on && exp_q.size() > 0) chk("scoreboard", act, exp_q.pop_front());

  initial begin
    stim_t s;
    vec_t e;
    #2;
    chk("reset_idle", act, '0);
    gen(RT, 0, 0);
    gen(LW, 2, 3);
    gen(BNE, 0, 0);
    gen(BEQ, 0, 0);
    gen(ORI, 0, 0);
    gen(ADDI, 0, 0);
    gen(BAD, 0, 0);
    gen(SW, 1, 2);
    gen(JMP, 0, 0);
    for (int n = 0; n < 40; n++) begin
      int k = $urandom_range(0, 12);
      gen(k == 12 ? 6'($urandom) : op_tab[k], $urandom_range(0, 2), $urandom_range(0, 3));
    end
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    mon_on = 1'b1;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      i_opcode = s.op; i_zero = s.zero; i_mem_ready = s.rdy;
      @(posedge i_clk); #1;
    end
    mon_on = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected cycles left, want 0", exp_q.size());
    end
    i_opcode = LW; i_mem_ready = 1'b1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_mem_ready = 1'b0;
    @(posedge i_clk); #1;
    e = v(3); e.mr = 1; e.iord = 1;
    chk("memrd_stall", act, e);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_reset", act, '0);
    @(posedge i_clk); #3;
    chk("reset_held", act, '0);
    i_rst_n = 1'b1;
    #1;
    e = v(0); e.mr = 1; e.sb = 2'b01;
    chk("post_reset_fetch", act, e);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
